// File: rtl/seg7_multi_digit_display.sv
// Multi-digit seven-segment driver: hex or decimal (serial double dabble),
// leading-zero blanking, overflow dashes and selectable pin polarity.
module seg7_multi_digit_display #(
    parameter int COUNT_WIDTH = 8,
    parameter int NUM_DIGITS  = 2,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Load,
    input  logic [COUNT_WIDTH-1:0]  i_Count,
    input  logic                    i_Dec_Mode,
    input  logic                    i_Blank_Zeros,
    output logic [7*NUM_DIGITS-1:0] o_Segments,
    output logic                    o_Busy,
    output logic                    o_Done,
    output logic                    o_Overflow
);

    localparam int BW   = 4 * NUM_DIGITS;
    localparam int SW   = 7 * NUM_DIGITS;
    localparam int XW   = (COUNT_WIDTH > BW) ? COUNT_WIDTH : BW;
    localparam int CNTW = $clog2(COUNT_WIDTH + 1);
    localparam logic [SW-1:0] SEG_OFF = {SW{ACTIVE_LOW}};

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

    state_t                 state_q;
    logic [COUNT_WIDTH-1:0] val_q;
    logic                   dec_q;
    logic                   blank_q;
    logic [BW-1:0]          bcd_q, bcd_d;
    logic                   carry_d;
    logic                   ovf_q;
    logic [CNTW-1:0]        cnt_q;
    logic [SW-1:0]          seg_q, seg_d;
    logic                   busy_q, done_q, ovf_out_q;
    logic                   disp_ovf_d;
    logic                   hex_ovf;
    logic [XW-1:0]          ext;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0:    return 7'h7E;
            4'h1:    return 7'h30;
            4'h2:    return 7'h6D;
            4'h3:    return 7'h79;
            4'h4:    return 7'h33;
            4'h5:    return 7'h5B;
            4'h6:    return 7'h5F;
            4'h7:    return 7'h70;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h7B;
            4'hA:    return 7'h77;
            4'hB:    return 7'h1F;
            4'hC:    return 7'h4E;
            4'hD:    return 7'h3D;
            4'hE:    return 7'h4F;
            default: return 7'h47;
        endcase
    endfunction

    assign ext = XW'(val_q);

    generate
        if (COUNT_WIDTH > BW) begin : g_hex_ovf
            assign hex_ovf = |val_q[COUNT_WIDTH-1:BW];
        end else begin : g_no_hex_ovf
            assign hex_ovf = 1'b0;
        end
    endgenerate

    // One double-dabble step: correct each BCD digit, then shift in the next MSB
    always_comb begin
        logic [BW-1:0] adj;
        adj = bcd_q;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        {carry_d, bcd_d} = {adj, val_q[COUNT_WIDTH-1]};
    end

    always_comb begin
        logic [BW-1:0] digits;
        logic [3:0]    nib;
        logic [6:0]    raw;
        logic          lead;
        digits     = dec_q ? bcd_q : ext[BW-1:0];
        disp_ovf_d = dec_q ? ovf_q : hex_ovf;
        lead       = 1'b1;
        nib        = 4'h0;
        raw        = 7'h00;
        seg_d      = '0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            nib = digits[4*d +: 4];
            if (disp_ovf_d) raw = 7'h01;
            else if (blank_q && lead && nib == 4'h0 && d != 0) raw = 7'h00;
            else raw = enc(nib);
            if (nib != 4'h0) lead = 1'b0;
            seg_d[7*d +: 7] = ACTIVE_LOW ? ~raw : raw;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            val_q     <= '0;
            dec_q     <= 1'b0;
            blank_q   <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            seg_q     <= SEG_OFF;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_Load) begin
                        val_q   <= i_Count;
                        dec_q   <= i_Dec_Mode;
                        blank_q <= i_Blank_Zeros;
                        bcd_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= i_Dec_Mode ? SHIFT : ENCODE;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    val_q <= val_q << 1;
                    ovf_q <= ovf_q | carry_d;
                    cnt_q <= cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(COUNT_WIDTH - 1)) state_q <= ENCODE;
                end
                ENCODE: begin
                    seg_q     <= seg_d;
                    ovf_out_q <= disp_ovf_d;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_Segments = seg_q;
    assign o_Busy     = busy_q;
    assign o_Done     = done_q;
    assign o_Overflow = ovf_out_q;

endmodule

// File: tb/tb_seg7_multi_digit_display.sv
// Randomised self-checking bench for seg7_multi_digit_display against a
// digit-arithmetic reference model.
module tb_seg7_multi_digit_display;

    localparam int CW = 8;
    localparam int ND = 2;
    localparam int SW = 7 * ND;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [CW-1:0] count;
    logic          dec_mode;
    logic          blank;
    logic [SW-1:0] segs;
    logic          busy;
    logic          done;
    logic          ovf;

    int nchk = 0;
    int nfail = 0;

    logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                             7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F,
                             7'h4E, 7'h3D, 7'h4F, 7'h47};

    always #5 clk = ~clk;

    seg7_multi_digit_display #(
        .COUNT_WIDTH(CW),
        .NUM_DIGITS (ND),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Load       (load),
        .i_Count      (count),
        .i_Dec_Mode   (dec_mode),
        .i_Blank_Zeros(blank),
        .o_Segments   (segs),
        .o_Busy       (busy),
        .o_Done       (done),
        .o_Overflow   (ovf)
    );

    function automatic int unsigned limit_of(input bit dm);
        int unsigned lim = 1;
        for (int d = 0; d < ND; d++) lim = lim * (dm ? 10 : 16);
        return lim;
    endfunction

    function automatic bit model_ovf(input int unsigned v, input bit dm);
        return v >= limit_of(dm);
    endfunction

    function automatic logic [SW-1:0] model_seg(input int unsigned v,
                                                input bit dm, input bit bz);
        logic [SW-1:0] r;
        logic [6:0]    raw;
        int unsigned   base, pw, dig;
        bit            of;
        r    = '0;
        base = dm ? 10 : 16;
        of   = model_ovf(v, dm);
        pw   = 1;
        for (int d = 0; d < ND; d++) begin
            dig = (v / pw) % base;
            if (of) raw = 7'h01;
            else if (bz && d > 0 && (v / pw) == 0) raw = 7'h00;
            else raw = tbl[dig];
            r[7*d +: 7] = ~raw;
            pw = pw * base;
        end
        return r;
    endfunction

    task automatic do_load(input int unsigned v, input bit dm, input bit bz);
        count    = CW'(v);
        dec_mode = dm;
        blank    = bz;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
        count = CW'($urandom);
        nchk++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nfail++;
            $display("FAIL capture v=%0d: busy=%b done=%b, want busy=1 done=0",
                     v, busy, done);
        end
    endtask

    task automatic wait_done(input int unsigned v, input bit dm, input bit bz);
        int  n = 0;
        bit  seen = 0;
        bit  bdrop = 0;
        int  lat = dm ? CW + 1 : 1;
        while (n < 40 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) seen = 1;
            else if (busy !== 1'b1) bdrop = 1;
        end
        nchk++;
        if (!seen || n != lat || bdrop) begin
            nfail++;
            $display("FAIL latency v=%0d dec=%0b: done after %0d (seen=%0b busy_drop=%0b), want %0d",
                     v, dm, n, seen, bdrop, lat);
        end
        nchk++;
        if (segs !== model_seg(v, dm, bz)) begin
            nfail++;
            $display("FAIL segments v=%0d dec=%0b blank=%0b: got %h want %h",
                     v, dm, bz, segs, model_seg(v, dm, bz));
        end
        nchk++;
        if (ovf !== model_ovf(v, dm) || busy !== 1'b0) begin
            nfail++;
            $display("FAIL flags v=%0d: ovf=%b busy=%b, want ovf=%b busy=0",
                     v, ovf, busy, model_ovf(v, dm));
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nchk++;
        if (segs !== 14'h3FFF || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            nfail++;
            $display("FAIL reset: segs=%h busy=%b done=%b ovf=%b, want 3fff 0 0 0",
                     segs, busy, done, ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_hex;
        logic [SW-1:0] held;
        do_load(8'hA5, 1'b0, 1'b0);
        wait_done(8'hA5, 1'b0, 1'b0);
        nchk++;
        if (segs !== {~7'h77, ~7'h5B}) begin
            nfail++;
            $display("FAIL hex_A5: got %h want %h", segs, {~7'h77, ~7'h5B});
        end
        held = segs;
        repeat (3) @(posedge clk);
        #1;
        nchk++;
        if (segs !== held || done !== 1'b0) begin
            nfail++;
            $display("FAIL hold: segs=%h done=%b, want %h 0", segs, done, held);
        end
    endtask

    task automatic test_decimal;
        do_load(42, 1'b1, 1'b0);
        wait_done(42, 1'b1, 1'b0);
        nchk++;
        if (segs !== {~7'h33, ~7'h6D}) begin
            nfail++;
            $display("FAIL dec_42: got %h want %h", segs, {~7'h33, ~7'h6D});
        end
    endtask

    task automatic test_overflow_blank;
        do_load(200, 1'b1, 1'b1);
        wait_done(200, 1'b1, 1'b1);
        nchk++;
        if (segs !== {~7'h01, ~7'h01} || ovf !== 1'b1) begin
            nfail++;
            $display("FAIL ovf_200: segs=%h ovf=%b, want %h 1", segs, ovf, {~7'h01, ~7'h01});
        end
        do_load(7, 1'b1, 1'b1);
        wait_done(7, 1'b1, 1'b1);
        nchk++;
        if (segs !== {7'h7F, ~7'h70} || ovf !== 1'b0) begin
            nfail++;
            $display("FAIL blank_7: segs=%h ovf=%b, want %h 0", segs, ovf, {7'h7F, ~7'h70});
        end
        do_load(0, 1'b1, 1'b1);
        wait_done(0, 1'b1, 1'b1);
        do_load(8'h0C, 1'b0, 1'b1);
        wait_done(8'h0C, 1'b0, 1'b1);
    endtask

    task automatic test_busy_drop;
        int ndone = 0;
        int at = 0;
        do_load(99, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        count    = 8'd11;
        dec_mode = 1'b1;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        for (int n = 4; n <= 24; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                at = n;
            end
        end
        nchk++;
        if (ndone != 1 || at != CW + 1 || segs !== model_seg(99, 1'b1, 1'b0)) begin
            nfail++;
            $display("FAIL busy_drop: %0d done pulses at edge %0d segs=%h, want 1 at %0d segs=%h",
                     ndone, at, segs, CW + 1, model_seg(99, 1'b1, 1'b0));
        end
    endtask

    task automatic test_encode_drop;
        int ndone = 0;
        do_load(8'h3C, 1'b0, 1'b0);
        count    = 8'h77;
        dec_mode = 1'b0;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        nchk++;
        if (done !== 1'b1 || segs !== model_seg(8'h3C, 1'b0, 1'b0)) begin
            nfail++;
            $display("FAIL encode_cycle: done=%b segs=%h, want 1 %h",
                     done, segs, model_seg(8'h3C, 1'b0, 1'b0));
        end
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        nchk++;
        if (ndone != 0 || segs !== model_seg(8'h3C, 1'b0, 1'b0)) begin
            nfail++;
            $display("FAIL encode_drop: %0d busy/done cycles segs=%h, want 0 %h",
                     ndone, segs, model_seg(8'h3C, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        do_load(123, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nchk++;
        if (segs !== 14'h3FFF || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            nfail++;
            $display("FAIL reset_mid: segs=%h busy=%b done=%b ovf=%b, want 3fff 0 0 0",
                     segs, busy, done, ovf);
        end
        for (int n = 0; n < 14; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1 || segs !== 14'h3FFF) bad++;
        end
        nchk++;
        if (bad != 0) begin
            nfail++;
            $display("FAIL reset_abort: %0d bad cycles after reset, want 0", bad);
        end
        do_load(57, 1'b1, 1'b1);
        wait_done(57, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back;
        do_load(8'h5E, 1'b0, 1'b0);
        wait_done(8'h5E, 1'b0, 1'b0);
        do_load(86, 1'b1, 1'b0);
        wait_done(86, 1'b1, 1'b0);
        do_load(3, 1'b1, 1'b1);
        wait_done(3, 1'b1, 1'b1);
    endtask

    task automatic test_random;
        int unsigned v;
        bit dm, bz;
        for (int i = 0; i < 40; i++) begin
            v  = $urandom_range(0, (1 << CW) - 1);
            dm = 1'($urandom);
            bz = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            do_load(v, dm, bz);
            wait_done(v, dm, bz);
        end
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        count    = '0;
        dec_mode = 1'b0;
        blank    = 1'b0;
        test_reset();
        test_hex();
        test_decimal();
        test_overflow_blank();
        test_busy_drop();
        test_encode_drop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
